// File: rtl/mp3dec_pkg.sv
// -----------------------------------------------------------------------------
// mp3dec_pkg
// Shared definitions for the MP3 decoder reset/enable sequencer.
//   - seq_state_t : state codes, also used by the AHB wrapper status register
//   - DEF_*       : default sequencer timing (HCLK cycles)
//   - helpers     : per-state output decode
// -----------------------------------------------------------------------------
package mp3dec_pkg;

    typedef enum logic [2:0] {
        S_HALT   = 3'd0,
        S_FRST   = 3'd1,
        S_SETTLE = 3'd2,
        S_WAITB  = 3'd3,
        S_DREL   = 3'd4,
        S_RUN    = 3'd5,
        S_ERR    = 3'd6
    } seq_state_t;

    localparam int DEF_RST_HOLD     = 16;
    localparam int DEF_SETTLE       = 4;
    localparam int DEF_BUSY_TIMEOUT = 1024;
    localparam int DEF_RUN_DELAY    = 2;
    localparam int DEF_CNT_W        = 11;

    // FIFOs are held in reset whenever the decoder is not being brought up or running.
    function automatic logic fifo_rst_for(input seq_state_t s);
        return (s == S_HALT) || (s == S_FRST) || (s == S_ERR);
    endfunction

    // Decoder reset is released only once the FIFOs are known to be out of reset.
    function automatic logic dec_rel_for(input seq_state_t s);
        return (s == S_DREL) || (s == S_RUN);
    endfunction

    function automatic logic busy_for(input seq_state_t s);
        return (s == S_FRST) || (s == S_SETTLE) || (s == S_WAITB) || (s == S_DREL);
    endfunction

endpackage

// File: rtl/mp3dec_seq_cnt.sv
// -----------------------------------------------------------------------------
// mp3dec_seq_cnt
// Clearable up-counter with terminal-count compare, used to time each
// sequencer state. Saturates at all-ones instead of wrapping.
// Ports:
//   clk_i     : clock
//   rst_ni    : async active-low reset (counter -> 0)
//   clr_i     : synchronous clear (takes priority over counting)
//   en_i      : count enable
//   tc_val_i  : terminal-count value for the current state
//   tc_o      : high while the count equals tc_val_i
// -----------------------------------------------------------------------------
module mp3dec_seq_cnt #(
    parameter int CNT_W = 11
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] tc_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/mp3dec_rst_seq.sv
// -----------------------------------------------------------------------------
// mp3dec_rst_seq
// Ordered bring-up of the MP3 decoder in the HCLK domain:
//   HALT -> FRST (hold FIFO reset) -> SETTLE -> WAITB (wait for FIFO
//   reset-busy flags) -> DREL (decoder reset released) -> RUN.
// A busy-flag timeout parks the sequencer in ERR with a sticky error.
// Ports:
//   HCLK, HRESETn     : bus clock, async active-low reset
//   start_req         : pulse, (re)run the full sequence
//   halt_req          : pulse, force held reset (wins over start_req)
//   en_req            : level, software decoder enable
//   ififo_wrrst_busy  : input FIFO write-side reset busy
//   ofifo_rdrst_busy  : output FIFO read-side reset busy
//   fifo_rst          : active-high reset to both FIFOs
//   dec_rst_n         : active-low decoder reset
//   dec_en            : decoder enable
//   seq_busy          : sequence in progress
//   seq_done          : one-cycle pulse on entry to RUN
//   seq_err           : sticky busy-flag timeout
//   seq_state         : current state code
// All outputs are registered.
// -----------------------------------------------------------------------------
module mp3dec_rst_seq
    import mp3dec_pkg::*;
#(
    parameter int RST_HOLD     = DEF_RST_HOLD,
    parameter int SETTLE       = DEF_SETTLE,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
    parameter int RUN_DELAY    = DEF_RUN_DELAY,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       start_req,
    input  logic       halt_req,
    input  logic       en_req,
    input  logic       ififo_wrrst_busy,
    input  logic       ofifo_rdrst_busy,
    output logic       fifo_rst,
    output logic       dec_rst_n,
    output logic       dec_en,
    output logic       seq_busy,
    output logic       seq_done,
    output logic       seq_err,
    output logic [2:0] seq_state
);

    localparam logic [CNT_W-1:0] TC_HOLD    = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] TC_SETTLE  = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] TC_TIMEOUT = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TC_RUN     = CNT_W'(RUN_DELAY - 1);

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic [CNT_W-1:0] tc_val;
    logic             tc;
    logic             cnt_clr;
    logic             err_d;

    logic fifo_rst_q;
    logic dec_rst_n_q;
    logic dec_en_q;
    logic seq_busy_q;
    logic seq_done_q;
    logic seq_err_q;

    // Next-state decode. Commands override the per-state progression,
    // with halt taking priority over start.
    always_comb begin
        state_d = state_q;
        tc_val  = '0;
        unique case (state_q)
            S_FRST: begin
                tc_val = TC_HOLD;
                if (tc) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                tc_val = TC_SETTLE;
                if (tc) state_d = S_WAITB;
            end
            S_WAITB: begin
                tc_val = TC_TIMEOUT;
                // Flags clearing on the terminal cycle still counts as success.
                if (!ififo_wrrst_busy && !ofifo_rdrst_busy) begin
                    state_d = S_DREL;
                end else if (tc) begin
                    state_d = S_ERR;
                end
            end
            S_DREL: begin
                tc_val = TC_RUN;
                if (tc) state_d = S_RUN;
            end
            default: begin
                state_d = state_q;
            end
        endcase

        if (start_req) state_d = S_FRST;
        if (halt_req)  state_d = S_HALT;

        // A restart from FRST is a re-entry, so it must clear the hold count too.
        cnt_clr = (state_d != state_q) || start_req;

        err_d = seq_err_q;
        if (start_req && !halt_req) err_d = 1'b0;
        if (state_d == S_ERR)       err_d = 1'b1;
    end

    mp3dec_seq_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_i    (HCLK),
        .rst_ni   (HRESETn),
        .clr_i    (cnt_clr),
        .en_i     (1'b1),
        .tc_val_i (tc_val),
        .tc_o     (tc)
    );

    // Outputs are decoded from the next state so they line up with seq_state.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_HALT;
            fifo_rst_q  <= 1'b1;
            dec_rst_n_q <= 1'b0;
            dec_en_q    <= 1'b0;
            seq_busy_q  <= 1'b0;
            seq_done_q  <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fifo_rst_q  <= fifo_rst_for(state_d);
            dec_rst_n_q <= dec_rel_for(state_d);
            dec_en_q    <= (state_d == S_RUN) && en_req;
            seq_busy_q  <= busy_for(state_d);
            seq_done_q  <= (state_d == S_RUN) && (state_q == S_DREL);
            seq_err_q   <= err_d;
        end
    end

    assign fifo_rst  = fifo_rst_q;
    assign dec_rst_n = dec_rst_n_q;
    assign dec_en    = dec_en_q;
    assign seq_busy  = seq_busy_q;
    assign seq_done  = seq_done_q;
    assign seq_err   = seq_err_q;
    assign seq_state = state_q;

endmodule

// File: tb/tb_mp3dec_rst_seq.sv
module tb_mp3dec_rst_seq;

    localparam int RST_HOLD     = 16;
    localparam int SETTLE       = 4;
    localparam int BUSY_TIMEOUT = 1024;
    localparam int RUN_DELAY    = 2;
    localparam int CNT_W        = 11;
    // First cycle (counted from the start_req cycle) spent waiting on busy flags.
    localparam int WS           = RST_HOLD + SETTLE + 1;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic       start_req;
    logic       halt_req;
    logic       en_req;
    logic       ififo_wrrst_busy;
    logic       ofifo_rdrst_busy;
    logic       fifo_rst;
    logic       dec_rst_n;
    logic       dec_en;
    logic       seq_busy;
    logic       seq_done;
    logic       seq_err;
    logic [2:0] seq_state;

    int checks   = 0;
    int failures = 0;

    mp3dec_rst_seq #(
        .RST_HOLD     (RST_HOLD),
        .SETTLE       (SETTLE),
        .BUSY_TIMEOUT (BUSY_TIMEOUT),
        .RUN_DELAY    (RUN_DELAY),
        .CNT_W        (CNT_W)
    ) dut (
        .HCLK             (HCLK),
        .HRESETn          (HRESETn),
        .start_req        (start_req),
        .halt_req         (halt_req),
        .en_req           (en_req),
        .ififo_wrrst_busy (ififo_wrrst_busy),
        .ofifo_rdrst_busy (ofifo_rdrst_busy),
        .fifo_rst         (fifo_rst),
        .dec_rst_n        (dec_rst_n),
        .dec_en           (dec_en),
        .seq_busy         (seq_busy),
        .seq_done         (seq_done),
        .seq_err          (seq_err),
        .seq_state        (seq_state)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Timeline model: a start_req in cycle 0; both busy flags are low from
    // cycle d onward. Returns the state code expected in cycle c.
    function automatic int exp_state(input int c, input int d);
        int rel;
        if (c <= 0)                 return 0;
        if (c <= RST_HOLD)          return 1;
        if (c < WS)                 return 2;
        rel = (d > WS) ? d : WS;
        if (rel - WS < BUSY_TIMEOUT) begin
            if (c <= rel)             return 3;
            if (c <= rel + RUN_DELAY) return 4;
            return 5;
        end
        if (c < WS + BUSY_TIMEOUT)  return 3;
        return 6;
    endfunction

    // Compare every output against what the state table says for state st.
    task automatic chk_all(input string tag, input int st, input logic den,
                           input logic done, input logic err);
        chk({tag, "_state"},     32'(seq_state), 32'(st));
        chk({tag, "_fifo_rst"},  32'(fifo_rst),  32'(st == 0 || st == 1 || st == 6));
        chk({tag, "_dec_rst_n"}, 32'(dec_rst_n), 32'(st == 4 || st == 5));
        chk({tag, "_seq_busy"},  32'(seq_busy),  32'(st >= 1 && st <= 4));
        chk({tag, "_dec_en"},    32'(dec_en),    32'(den));
        chk({tag, "_seq_done"},  32'(seq_done),  32'(done));
        chk({tag, "_seq_err"},   32'(seq_err),   32'(err));
    endtask

    // One full sequence: ififo low from cycle bi, ofifo low from cycle bo.
    // With rnd set, en_req is random every cycle and the busy flags are
    // randomly re-asserted once the decoder reset has been released.
    task automatic run_seq(input string tag, input int bi, input int bo, input int ncyc,
                           input bit rnd, output int done_cyc, output int done_cnt);
        int   d;
        int   st;
        int   pst;
        logic en_prev;
        d        = (bi > bo) ? bi : bo;
        done_cyc = -1;
        done_cnt = 0;
        start_req        = 1'b1;
        halt_req         = 1'b0;
        ififo_wrrst_busy = (bi > 0);
        ofifo_rdrst_busy = (bo > 0);
        en_req           = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            en_prev = en_req;
            tick();
            start_req = 1'b0;
            st  = exp_state(c, d);
            pst = exp_state(c - 1, d);
            chk_all(tag, st, en_prev && (st == 5), (st == 5) && (pst == 4), st == 6);
            if (seq_done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (rnd && (st == 4 || st == 5)) begin
                ififo_wrrst_busy = 1'($urandom_range(0, 1));
                ofifo_rdrst_busy = 1'($urandom_range(0, 1));
            end else begin
                ififo_wrrst_busy = (c < bi);
                ofifo_rdrst_busy = (c < bo);
            end
            en_req = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        ififo_wrrst_busy = 1'b0;
        ofifo_rdrst_busy = 1'b0;
    endtask

    initial begin
        int dc;
        int dn;
        int bi;
        int bo;
        int mx;

        start_req        = 1'b0;
        halt_req         = 1'b0;
        en_req           = 1'b0;
        ififo_wrrst_busy = 1'b0;
        ofifo_rdrst_busy = 1'b0;
        HRESETn          = 1'b1;
        #2 HRESETn = 1'b0;
        #2;
        chk_all("reset", 0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        #3 HRESETn = 1'b1;
        tick();
        chk_all("post_reset", 0, 1'b0, 1'b0, 1'b0);

        // Nominal bring-up with busy flags already low.
        run_seq("nominal", 0, 0, 30, 1'b0, dc, dn);
        chk("nominal_done_cycle", 32'(dc), 32'd24);
        chk("nominal_done_count", 32'(dn), 32'd1);

        // Input FIFO busy for 50 cycles after fifo_rst falls (falls at cycle 17).
        run_seq("ibusy", 67, 0, 80, 1'b0, dc, dn);
        chk("ibusy_done_cycle", 32'(dc), 32'd70);

        // Output FIFO busy stuck: timeout into ERR at cycle WS + BUSY_TIMEOUT.
        run_seq("timeout", 0, 100000, WS + BUSY_TIMEOUT + 1, 1'b0, dc, dn);
        chk("timeout_done_count", 32'(dn), 32'd0);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk_all("err_halt", 0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        chk("err_sticky_halt", 32'(seq_err), 32'd1);
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        chk("err_clear_start", 32'(seq_err), 32'd0);
        chk("err_clear_state", 32'(seq_state), 32'd1);

        // Halt from RUN with the decoder enabled.
        run_seq("to_run", 0, 0, 26, 1'b0, dc, dn);
        chk("run_dec_en", 32'(dec_en), 32'd1);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk_all("halt_run", 0, 1'b0, 1'b0, 1'b0);

        // Simultaneous start and halt during SETTLE: halt wins.
        start_req = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            start_req = 1'b0;
        end
        chk("settle_state", 32'(seq_state), 32'd2);
        start_req = 1'b1;
        halt_req  = 1'b1;
        tick();
        start_req = 1'b0;
        halt_req  = 1'b0;
        chk_all("start_halt", 0, 1'b0, 1'b0, 1'b0);

        // Restart during FRST at cycle 5: one seq_done, 24 cycles after the restart.
        dc = -1;
        dn = 0;
        start_req = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            start_req = (c == 5);
            if (c == 17) chk("restart_still_frst", 32'(seq_state), 32'd1);
            if (seq_done === 1'b1) begin
                dn++;
                if (dc < 0) dc = c;
            end
        end
        chk("restart_done_count", 32'(dn), 32'd1);
        chk("restart_done_cycle", 32'(dc), 32'd29);

        // Async reset while waiting on a busy flag.
        ififo_wrrst_busy = 1'b1;
        start_req        = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            tick();
            start_req = 1'b0;
        end
        chk("waitb_state", 32'(seq_state), 32'd3);
        #2 HRESETn = 1'b0;
        #1;
        chk_all("async_rst", 0, 1'b0, 1'b0, 1'b0);
        tick();
        #3 HRESETn = 1'b1;
        ififo_wrrst_busy = 1'b0;
        tick();
        chk_all("after_async_rst", 0, 1'b0, 1'b0, 1'b0);

        // Randomised busy release times, random en_req and flag noise.
        for (int r = 0; r < 6; r++) begin
            bi = $urandom_range(0, 90);
            bo = $urandom_range(0, 90);
            mx = (bi > bo) ? bi : bo;
            if (mx < WS) mx = WS;
            run_seq("rand", bi, bo, mx + RUN_DELAY + 10, 1'b1, dc, dn);
            chk("rand_done_cycle", 32'(dc), 32'(mx + RUN_DELAY + 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
